// File: rtl/circ_pkg.sv
// Shared state type and circulant index helpers for circulant_transpose_stream.
// Both helpers wrap modulo n, which must be a power of two.
package circ_pkg;

   typedef enum logic {StFill, StDrain} circ_state_e;

   function automatic int unsigned bank_of(int unsigned row, int unsigned col, int unsigned n);
      return (row + col) & (n - 1);
   endfunction

   function automatic int unsigned addr_of(int unsigned bank, int unsigned col, int unsigned n);
      return (bank + n - col) & (n - 1);
   endfunction

endpackage

// File: rtl/circ_bank.sv
// One circulant storage bank: W-bit x Depth simple dual-port RAM with registered read.
// The read register holds its value while re_i is low.
module circ_bank #(
   parameter int unsigned W     = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(Depth)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(Depth)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] mem_q [Depth];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/circulant_transpose_stream.sv
// Streaming N x N transpose: rows in, columns out, through N circulant banks.
// Bank read registers form the first output entry; s_* is the skid entry behind it.
module circulant_transpose_stream
   import circ_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [N*W-1:0]       in_row_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [N*W-1:0]       out_col_o,
   output logic [$clog2(N)-1:0] out_col_idx_o,
   output logic                 out_last_o
);

   localparam int unsigned   AW      = $clog2(N);
   localparam logic [AW-1:0] LastIdx = AW'(N - 1);

   circ_state_e   state_q;
   logic [AW-1:0] wr_row_q, rd_col_q, p_idx_q, s_idx_q, head_idx;
   logic          rd_done_q, p_vld_q, p_vld_d, s_vld_q, s_vld_d, s_load;
   logic [N*W-1:0] s_col_q, p_col;
   logic          wr_fire, pop, issue, last_pop;
   logic [W-1:0]  bank_wdata [N];
   logic [W-1:0]  bank_rdata [N];
   logic [AW-1:0] bank_raddr [N];

   assign in_ready_o  = (state_q == StFill);
   assign wr_fire     = in_valid_i & in_ready_o;
   assign out_valid_o = p_vld_q | s_vld_q;
   assign pop         = out_valid_o & out_ready_i;
   assign head_idx    = s_vld_q ? s_idx_q : p_idx_q;
   assign last_pop    = pop & (head_idx == LastIdx);
   // A read may only land in the bank registers once their current column has somewhere to go.
   assign issue       = (state_q == StDrain) & ~rd_done_q & (~s_vld_q | pop);

   always_comb begin
      for (int unsigned b = 0; b < N; b++) begin
         bank_wdata[b] = in_row_i[addr_of(b, 32'(wr_row_q), N)*W +: W];
         bank_raddr[b] = AW'(addr_of(b, 32'(rd_col_q), N));
      end
      for (int unsigned r = 0; r < N; r++) begin
         p_col[r*W +: W] = bank_rdata[AW'(bank_of(r, 32'(p_idx_q), N))];
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_bank
      circ_bank #(
         .W     (W),
         .Depth (N)
      ) u_bank (
         .clk_i   (clk_i),
         .we_i    (wr_fire),
         .waddr_i (wr_row_q),
         .wdata_i (bank_wdata[g]),
         .re_i    (issue),
         .raddr_i (bank_raddr[g]),
         .rdata_o (bank_rdata[g])
      );
   end

   always_comb begin
      p_vld_d = p_vld_q;
      s_vld_d = s_vld_q;
      s_load  = 1'b0;
      if (s_vld_q) begin
         if (pop) begin
            s_vld_d = p_vld_q;
            s_load  = p_vld_q;
            p_vld_d = issue;
         end
      end else begin
         if (p_vld_q && !pop && issue) begin
            s_vld_d = 1'b1;
            s_load  = 1'b1;
         end
         if (issue) p_vld_d = 1'b1;
         else if (pop) p_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StFill;
         wr_row_q  <= '0;
         rd_col_q  <= '0;
         rd_done_q <= 1'b0;
      end else begin
         unique case (state_q)
            StFill: begin
               if (wr_fire) begin
                  wr_row_q <= wr_row_q + AW'(1);
                  if (wr_row_q == LastIdx) state_q <= StDrain;
               end
            end
            StDrain: begin
               if (issue) begin
                  rd_col_q <= rd_col_q + AW'(1);
                  if (rd_col_q == LastIdx) rd_done_q <= 1'b1;
               end
               if (last_pop) begin
                  state_q   <= StFill;
                  rd_done_q <= 1'b0;
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_vld_q <= 1'b0;
         s_vld_q <= 1'b0;
         p_idx_q <= '0;
         s_idx_q <= '0;
         s_col_q <= '0;
      end else begin
         p_vld_q <= p_vld_d;
         s_vld_q <= s_vld_d;
         if (issue) p_idx_q <= rd_col_q;
         if (s_load) begin
            s_col_q <= p_col;
            s_idx_q <= p_idx_q;
         end
      end
   end

   assign out_col_o     = s_vld_q ? s_col_q : (p_vld_q ? p_col : '0);
   assign out_col_idx_o = out_valid_o ? head_idx : '0;
   assign out_last_o    = out_valid_o & (head_idx == LastIdx);

endmodule

// File: tb/tb_circulant_transpose_stream.sv
// Bench for circulant_transpose_stream: directed N=4 scenarios plus a random N=8 run,
// each checked every cycle against a queue-based transpose model.
module tb_circulant_transpose_stream;

   localparam int unsigned N = 4, W = 8, N8 = 8, W8 = 16;

   logic clk = 1'b0;
   logic rst_n, rst8_n;
   always #5 clk = ~clk;

   logic           in_valid, in_ready, out_valid, out_ready, out_last;
   logic [N*W-1:0] in_row, out_col;
   logic [1:0]     out_idx;

   logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
   logic [N8*W8-1:0] b_in_row, b_out_col;
   logic [2:0]       b_out_idx;

   int checks = 0, errors = 0;

   circulant_transpose_stream #(.N(N), .W(W)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_row_i(in_row), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_col_o(out_col), .out_col_idx_o(out_idx), .out_last_o(out_last)
   );

   circulant_transpose_stream #(.N(N8), .W(W8)) u_dut8 (
      .clk_i(clk), .rst_ni(rst8_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
      .in_row_i(b_in_row), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
      .out_col_o(b_out_col), .out_col_idx_o(b_out_idx), .out_last_o(b_out_last)
   );

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   // ---------------- N=4 model: rows collected, transpose queued as expected columns
   logic [W-1:0]   m4 [N][N];
   logic [N*W-1:0] q4_col [$];
   int             q4_idx [$];
   logic [N*W-1:0] obs [$];
   logic [N*W-1:0] tmp4, prev_col;
   logic [1:0]     prev_idx;
   int             row4 = 0, pops = 0;
   bit             drain4 = 0, d0, prev_stall = 0, record = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         q4_col.delete();
         q4_idx.delete();
         row4       = 0;
         drain4     = 0;
         prev_stall = 0;
      end else begin
         d0 = drain4;
         check("in_ready", in_ready, !d0);
         if (prev_stall) begin
            check("out_valid held in stall", out_valid, 1);
            check("out_col stable in stall", out_col, prev_col);
            check("out_col_idx stable in stall", out_idx, prev_idx);
         end
         if (out_valid) begin
            check("column expected", q4_col.size() != 0, 1);
            if (q4_col.size() != 0) begin
               check("out_col", out_col, q4_col[0]);
               check("out_col_idx", out_idx, q4_idx[0]);
               check("out_last", out_last, q4_idx[0] == N - 1);
               if (out_ready) begin
                  if (record) obs.push_back(out_col);
                  if (q4_idx[0] == N - 1) drain4 = 0;
                  q4_col.pop_front();
                  q4_idx.pop_front();
                  pops++;
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_col   = out_col;
         prev_idx   = out_idx;
         if (in_valid && !d0) begin
            for (int c = 0; c < N; c++) m4[row4][c] = in_row[c*W +: W];
            row4++;
            if (row4 == N) begin
               row4   = 0;
               drain4 = 1;
               for (int c = 0; c < N; c++) begin
                  for (int r = 0; r < N; r++) tmp4[r*W +: W] = m4[r][c];
                  q4_col.push_back(tmp4);
                  q4_idx.push_back(c);
               end
            end
         end
      end
   end

   // ---------------- N=8 model
   logic [W8-1:0]    m8 [N8][N8];
   logic [N8*W8-1:0] q8_col [$];
   int               q8_idx [$];
   logic [N8*W8-1:0] tmp8;
   int               row8 = 0;
   bit               drain8 = 0, d8, b_prod_done = 0;

   always @(negedge clk) begin
      if (rst8_n) begin
         d8 = drain8;
         check("b in_ready", b_in_ready, !d8);
         if (b_out_valid && b_out_ready) begin
            check("b column expected", q8_col.size() != 0, 1);
            if (q8_col.size() != 0) begin
               check("b out_col", b_out_col, q8_col[0]);
               check("b out_col_idx", b_out_idx, q8_idx[0]);
               check("b out_last", b_out_last, q8_idx[0] == N8 - 1);
               if (q8_idx[0] == N8 - 1) drain8 = 0;
               q8_col.pop_front();
               q8_idx.pop_front();
            end
         end
         if (b_in_valid && !d8) begin
            for (int c = 0; c < N8; c++) m8[row8][c] = b_in_row[c*W8 +: W8];
            row8++;
            if (row8 == N8) begin
               row8   = 0;
               drain8 = 1;
               for (int c = 0; c < N8; c++) begin
                  for (int r = 0; r < N8; r++) tmp8[r*W8 +: W8] = m8[r][c];
                  q8_col.push_back(tmp8);
                  q8_idx.push_back(c);
               end
            end
         end
      end
   end

   // ---------------- N=4 stimulus helpers
   bit rand_ready = 0;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      end
   end

   function automatic logic [N*W-1:0] mk_row(int kind, int r);
      logic [N*W-1:0] row;
      for (int c = 0; c < N; c++) begin
         if (kind == 0) row[c*W +: W] = W'(16 * r + c);
         else if (kind == 1) row[c*W +: W] = W'(8'hA0 + 4 * r + c);
         else row[c*W +: W] = W'($urandom());
      end
      return row;
   endfunction

   task automatic send_row4(input logic [N*W-1:0] row);
      bit got = 0;
      in_valid = 1'b1;
      in_row   = row;
      for (int t = 0; t < 300 && !got; t++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
      end
      if (!got) check("row accepted in time", got, 1);
   endtask

   task automatic send_mat4(input int kind);
      for (int r = 0; r < N; r++) send_row4(mk_row(kind, r));
   endtask

   task automatic wait_idle4();
      bit idle = 0;
      for (int t = 0; t < 300 && !idle; t++) begin
         @(negedge clk);
         #1 idle = !drain4 && q4_col.size() == 0 && row4 == 0;
      end
      check("matrix drained in time", idle, 1);
      @(posedge clk);
      #1;
   endtask

   // ---------------- N=8 random producer and consumer
   initial begin
      b_out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 b_out_ready = 1'($urandom_range(1, 0));
      end
   end

   initial begin
      bit acc;
      b_in_valid = 1'b0;
      b_in_row   = '0;
      rst8_n     = 1'b1;
      #1 rst8_n  = 1'b0;
      #20 rst8_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3 * N8; k++) begin
         b_in_row = {$urandom(), $urandom(), $urandom(), $urandom()};
         acc      = 0;
         for (int t = 0; t < 500 && !acc; t++) begin
            b_in_valid = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
            @(posedge clk);
            #1;
         end
         if (!acc) check("b row accepted in time", acc, 1);
      end
      b_in_valid  = 1'b0;
      b_prod_done = 1;
   end

   // ---------------- main N=4 sequence
   logic [31:0] lit [4] = '{32'h30201000, 32'h31211101, 32'h32221202, 32'h33231303};

   initial begin
      bit done;
      in_valid = 1'b0;
      in_row   = '0;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset out_col", out_col, 0);
      check("reset out_col_idx", out_idx, 0);
      check("reset out_last", out_last, 0);
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // A with out_ready high: first column two cycles after the last row handshake
      record = 1;
      send_mat4(0);
      in_valid = 1'b0;
      @(negedge clk);
      check("out_valid low at T+1", out_valid, 0);
      @(negedge clk);
      check("out_valid high at T+2", out_valid, 1);
      @(posedge clk);
      #1;
      wait_idle4();
      record = 0;
      check("A column count", obs.size(), 4);
      for (int k = 0; k < 4; k++) check("A literal column", obs[k], lit[k]);

      // A again with random backpressure
      rand_ready = 1;
      send_mat4(0);
      in_valid = 1'b0;
      wait_idle4();

      // back-to-back matrices with in_valid held high
      send_mat4(2);
      send_mat4(2);
      in_valid = 1'b0;
      wait_idle4();

      // garbage offered during DRAIN must be ignored
      rand_ready = 0;
      send_mat4(2);
      for (int k = 0; k < N - 1; k++) begin
         in_valid = 1'($urandom_range(1, 0));
         in_row   = mk_row(2, 0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_idle4();
      send_mat4(0);
      in_valid = 1'b0;
      wait_idle4();

      // reset after column 1 is delivered, then a fresh matrix B
      send_mat4(0);
      in_valid = 1'b0;
      begin
         int p0;
         p0   = pops;
         done = 0;
         for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            #1 done = (pops >= p0 + 2);
         end
         check("columns 0,1 delivered before reset", done, 1);
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid reset out_valid", out_valid, 0);
      check("mid reset in_ready", in_ready, 1);
      check("mid reset out_last", out_last, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      record = 1;
      obs.delete();
      send_mat4(1);
      in_valid = 1'b0;
      wait_idle4();
      record = 0;
      check("B column count", obs.size(), 4);
      check("B column 0", obs[0], 32'hAC_A8_A4_A0);
      check("B column 3", obs[3], 32'hAF_AB_A7_A3);

      // let the N=8 run finish
      done = 0;
      for (int t = 0; t < 20000 && !done; t++) begin
         @(negedge clk);
         #1 done = b_prod_done && !drain8 && q8_col.size() == 0 && row8 == 0;
      end
      check("N=8 run completed", done, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
